// File: rtl/multi_timer_irq_controller.sv
// Multi-channel millisecond delay timer. Each channel counts whole milliseconds and raises a
// sticky pending flag on expiry; pending flags are masked and priority-encoded into irq/irq_id.
module multi_timer_irq_controller #(
    parameter int MFREQ_KHZ = 20000,
    parameter int NCH       = 4,
    parameter int DLY_W     = 16,
    localparam int CYC_W    = (MFREQ_KHZ > 1) ? $clog2(MFREQ_KHZ) : 1,
    localparam int ID_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 mclk,
    input  logic                 rst,
    input  logic [NCH-1:0]       start,
    input  logic [NCH-1:0]       stop,
    input  logic [NCH-1:0]       periodic,
    input  logic [NCH*DLY_W-1:0] delay_ms,
    input  logic [NCH-1:0]       irq_mask,
    input  logic [NCH-1:0]       ack,
    output logic [NCH-1:0]       active,
    output logic [NCH-1:0]       pending,
    output logic [NCH-1:0]       overrun,
    output logic                 irq,
    output logic [ID_W-1:0]      irq_id
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MFREQ_KHZ - 1);

    state_t           state_r [NCH];
    state_t           state_n [NCH];
    logic [CYC_W-1:0] cyc_r   [NCH];
    logic [CYC_W-1:0] cyc_n   [NCH];
    logic [DLY_W-1:0] ms_r    [NCH];
    logic [DLY_W-1:0] ms_n    [NCH];
    logic [DLY_W-1:0] dly_r   [NCH];
    logic [DLY_W-1:0] dly_n   [NCH];
    logic [NCH-1:0]   mode_r, mode_n;
    logic [NCH-1:0]   start_q;
    logic [NCH-1:0]   pending_r, pending_n;
    logic [NCH-1:0]   overrun_r, overrun_n;
    logic [NCH-1:0]   start_edge, expire, fire;

    assign start_edge = start & ~start_q;

    always_comb begin
        expire = '0;
        for (int i = 0; i < NCH; i++) begin
            expire[i] = (state_r[i] == RUN) && (cyc_r[i] == CYC_LAST)
                        && (ms_r[i] == dly_r[i] - DLY_W'(1));
        end
    end

    // stop suppresses an expiry in the same cycle; a set beats a simultaneous ack
    assign fire      = expire & ~stop;
    assign pending_n = (pending_r & ~ack) | fire;
    assign overrun_n = (overrun_r & ~ack) | (fire & pending_r & ~ack);

    always_comb begin
        mode_n = mode_r;
        for (int i = 0; i < NCH; i++) begin
            state_n[i] = state_r[i];
            cyc_n[i]   = cyc_r[i];
            ms_n[i]    = ms_r[i];
            dly_n[i]   = dly_r[i];
            if (stop[i]) begin
                state_n[i] = IDLE;
                cyc_n[i]   = '0;
                ms_n[i]    = '0;
            end else if (start_edge[i]) begin
                state_n[i] = RUN;
                cyc_n[i]   = '0;
                ms_n[i]    = '0;
                dly_n[i]   = (delay_ms[i*DLY_W +: DLY_W] == '0) ? DLY_W'(1)
                                                                 : delay_ms[i*DLY_W +: DLY_W];
                mode_n[i]  = periodic[i];
            end else if (state_r[i] == RUN) begin
                if (cyc_r[i] == CYC_LAST) begin
                    cyc_n[i] = '0;
                    if (expire[i]) begin
                        ms_n[i] = '0;
                        if (!mode_r[i]) state_n[i] = IDLE;
                    end else begin
                        ms_n[i] = ms_r[i] + DLY_W'(1);
                    end
                end else begin
                    cyc_n[i] = cyc_r[i] + CYC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                state_r[i] <= IDLE;
                cyc_r[i]   <= '0;
                ms_r[i]    <= '0;
                dly_r[i]   <= '0;
            end
            mode_r    <= '0;
            start_q   <= '0;
            pending_r <= '0;
            overrun_r <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_r[i] <= state_n[i];
                cyc_r[i]   <= cyc_n[i];
                ms_r[i]    <= ms_n[i];
                dly_r[i]   <= dly_n[i];
            end
            mode_r    <= mode_n;
            start_q   <= start;
            pending_r <= pending_n;
            overrun_r <= overrun_n;
        end
    end

    always_comb begin
        active = '0;
        for (int i = 0; i < NCH; i++) active[i] = (state_r[i] == RUN);
    end

    assign pending = pending_r;
    assign overrun = overrun_r;
    assign irq     = |(pending_r & irq_mask);

    // Scan downward so the lowest pending, unmasked index is left in irq_id
    always_comb begin
        irq_id = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pending_r[i] && irq_mask[i]) irq_id = ID_W'(i);
        end
    end

endmodule

// File: tb/tb_multi_timer_irq_controller.sv
// Bench for multi_timer_irq_controller: directed scenarios with fixed expectations, then random
// traffic checked against an absolute-deadline reference model.
module tb_multi_timer_irq_controller;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int DW = 16;

    logic            mclk;
    logic            rst;
    logic [N-1:0]    start, stop, periodic, irq_mask, ack;
    logic [N*DW-1:0] delay_ms;
    logic [N-1:0]    active, pending, overrun;
    logic            irq;
    logic [1:0]      irq_id;

    int err_cnt = 0;
    int chk_cnt = 0;

    multi_timer_irq_controller #(.MFREQ_KHZ(M), .NCH(N), .DLY_W(DW)) dut (
        .mclk(mclk), .rst(rst), .start(start), .stop(stop), .periodic(periodic),
        .delay_ms(delay_ms), .irq_mask(irq_mask), .ack(ack), .active(active),
        .pending(pending), .overrun(overrun), .irq(irq), .irq_id(irq_id)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Reference model: each running channel holds an absolute expiry deadline in edge counts
    int       t = 0;
    bit       m_run [N];
    longint   m_deadline [N];
    longint   m_period [N];
    bit       m_mode [N];
    bit [N-1:0] m_pending, m_overrun, m_start_q;

    always @(posedge mclk) begin
        bit pb, sedge, fire;
        longint dm;
        t++;
        if (rst) begin
            for (int i = 0; i < N; i++) m_run[i] = 0;
            m_pending = '0;
            m_overrun = '0;
            m_start_q = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                sedge = start[i] && !m_start_q[i];
                fire  = m_run[i] && (m_deadline[i] == t) && !stop[i];
                pb    = m_pending[i];
                if (ack[i]) begin
                    m_pending[i] = 0;
                    m_overrun[i] = 0;
                end
                if (fire) begin
                    if (pb && !ack[i]) m_overrun[i] = 1;
                    m_pending[i] = 1;
                end
                if (stop[i]) begin
                    m_run[i] = 0;
                end else if (sedge) begin
                    dm = longint'(delay_ms[i*DW +: DW]);
                    if (dm == 0) dm = 1;
                    m_run[i]      = 1;
                    m_period[i]   = dm * M;
                    m_deadline[i] = t + dm * M;
                    m_mode[i]     = periodic[i];
                end else if (fire) begin
                    if (m_mode[i]) m_deadline[i] = m_deadline[i] + m_period[i];
                    else m_run[i] = 0;
                end
            end
            m_start_q = start;
        end
    end

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_dly(input int ch, input int v);
        delay_ms[ch*DW +: DW] = DW'(v);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = '0; stop = '0; ack = '0; periodic = '0; irq_mask = '1;
        ticks(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        ticks(2);
        chk_cnt++; if (active !== 4'b0000) begin err_cnt++; $display("FAIL reset_active got=%b exp=0000", active); end
        chk_cnt++; if (pending !== 4'b0000) begin err_cnt++; $display("FAIL reset_pending got=%b exp=0000", pending); end
        chk_cnt++; if (overrun !== 4'b0000) begin err_cnt++; $display("FAIL reset_overrun got=%b exp=0000", overrun); end
        chk_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL reset_irq got=%b exp=0", irq); end
        chk_cnt++; if (irq_id !== 2'd0) begin err_cnt++; $display("FAIL reset_irq_id got=%0d exp=0", irq_id); end
        rst = 1'b0;
    endtask

    task automatic test_oneshot();
        do_reset();
        set_dly(0, 3);
        start[0] = 1'b1; tick(); start[0] = 1'b0;               // E0
        chk_cnt++; if (active !== 4'b0001) begin err_cnt++; $display("FAIL oneshot_active got=%b exp=0001", active); end
        ticks(11);                                              // E0+11
        chk_cnt++; if (pending !== 4'b0000) begin err_cnt++; $display("FAIL oneshot_early got=%b exp=0000", pending); end
        tick();                                                 // E0+12
        chk_cnt++; if (pending !== 4'b0001) begin err_cnt++; $display("FAIL oneshot_pending got=%b exp=0001", pending); end
        chk_cnt++; if (irq !== 1'b1 || irq_id !== 2'd0) begin err_cnt++; $display("FAIL oneshot_irq got=%b/%0d exp=1/0", irq, irq_id); end
        chk_cnt++; if (active !== 4'b0000) begin err_cnt++; $display("FAIL oneshot_idle got=%b exp=0000", active); end
        ack = 4'b0010; tick(); ack = '0;                        // E0+13, ack of idle bit
        chk_cnt++; if (pending !== 4'b0001) begin err_cnt++; $display("FAIL ack_not_pending got=%b exp=0001", pending); end
        tick();                                                 // E0+14
        irq_mask[0] = 1'b0; #1;
        chk_cnt++; if (irq !== 1'b0 || pending !== 4'b0001) begin err_cnt++; $display("FAIL masked got=%b/%b exp=0/0001", irq, pending); end
        irq_mask[0] = 1'b1; #1;
        chk_cnt++; if (irq !== 1'b1) begin err_cnt++; $display("FAIL unmask got=%b exp=1", irq); end
        ack[0] = 1'b1; tick(); ack = '0;                        // E0+15
        chk_cnt++; if (pending !== 4'b0000 || irq !== 1'b0) begin err_cnt++; $display("FAIL oneshot_ack got=%b/%b exp=0000/0", pending, irq); end
    endtask

    task automatic test_periodic();
        do_reset();
        set_dly(1, 2); periodic[1] = 1'b1;
        start[1] = 1'b1; tick(); start[1] = 1'b0;               // E0
        ticks(7);
        chk_cnt++; if (pending !== 4'b0000) begin err_cnt++; $display("FAIL per_early got=%b exp=0000", pending); end
        tick();                                                 // +8
        chk_cnt++; if (pending !== 4'b0010 || overrun !== 4'b0000) begin err_cnt++; $display("FAIL per_first got=%b/%b exp=0010/0000", pending, overrun); end
        ticks(7);                                               // +15
        chk_cnt++; if (overrun !== 4'b0000) begin err_cnt++; $display("FAIL per_ovr_early got=%b exp=0000", overrun); end
        tick();                                                 // +16
        chk_cnt++; if (overrun !== 4'b0010) begin err_cnt++; $display("FAIL per_overrun got=%b exp=0010", overrun); end
        ticks(8);                                               // +24
        chk_cnt++; if (active !== 4'b0010) begin err_cnt++; $display("FAIL per_running got=%b exp=0010", active); end
        ticks(5);
        stop[1] = 1'b1; tick(); stop = '0;                      // +30
        chk_cnt++; if (active !== 4'b0000 || pending !== 4'b0010 || overrun !== 4'b0010) begin
            err_cnt++; $display("FAIL per_stop got=%b/%b/%b exp=0000/0010/0010", active, pending, overrun);
        end
    endtask

    task automatic test_priority();
        do_reset();
        set_dly(2, 0); set_dly(3, 0);
        start = 4'b1100; tick(); start = '0;                    // E0
        ticks(3);
        chk_cnt++; if (pending !== 4'b0000) begin err_cnt++; $display("FAIL zero_early got=%b exp=0000", pending); end
        tick();                                                 // +4
        chk_cnt++; if (pending !== 4'b1100 || irq_id !== 2'd2) begin err_cnt++; $display("FAIL prio_both got=%b/%0d exp=1100/2", pending, irq_id); end
        ack[2] = 1'b1; tick(); ack = '0;
        chk_cnt++; if (pending !== 4'b1000 || irq_id !== 2'd3) begin err_cnt++; $display("FAIL prio_next got=%b/%0d exp=1000/3", pending, irq_id); end
    endtask

    task automatic test_retrigger();
        do_reset();
        set_dly(0, 5);
        start[0] = 1'b1; tick(); start[0] = 1'b0;               // E0
        ticks(11);
        start[0] = 1'b1; tick(); start[0] = 1'b0;               // +12
        ticks(8);                                               // +20
        chk_cnt++; if (pending !== 4'b0000) begin err_cnt++; $display("FAIL retrig_old got=%b exp=0000", pending); end
        ticks(11);                                              // +31
        chk_cnt++; if (pending !== 4'b0000) begin err_cnt++; $display("FAIL retrig_early got=%b exp=0000", pending); end
        tick();                                                 // +32
        chk_cnt++; if (pending !== 4'b0001) begin err_cnt++; $display("FAIL retrig_new got=%b exp=0001", pending); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_dly(0, 1); periodic[0] = 1'b1;
        start[0] = 1'b1; tick(); start[0] = 1'b0;               // E0
        ticks(4);                                               // +4
        chk_cnt++; if (pending !== 4'b0001) begin err_cnt++; $display("FAIL sim_first got=%b exp=0001", pending); end
        ticks(3);
        ack[0] = 1'b1; tick(); ack = '0;                        // +8, ack with expiry
        chk_cnt++; if (pending !== 4'b0001 || overrun !== 4'b0000) begin err_cnt++; $display("FAIL sim_ack got=%b/%b exp=0001/0000", pending, overrun); end
        tick();
        ack[0] = 1'b1; tick(); ack = '0;                        // +10
        chk_cnt++; if (pending !== 4'b0000) begin err_cnt++; $display("FAIL sim_clear got=%b exp=0000", pending); end
        tick();
        stop[0] = 1'b1; tick(); stop = '0;                      // +12, stop with expiry
        chk_cnt++; if (pending !== 4'b0000 || active !== 4'b0000) begin err_cnt++; $display("FAIL sim_stop got=%b/%b exp=0000/0000", pending, active); end
        ticks(8);
        chk_cnt++; if (pending !== 4'b0000) begin err_cnt++; $display("FAIL sim_stop_later got=%b exp=0000", pending); end
        stop[0] = 1'b1; start[0] = 1'b1; tick(); stop = '0; start = '0;
        chk_cnt++; if (active !== 4'b0000) begin err_cnt++; $display("FAIL sim_stop_start got=%b exp=0000", active); end
    endtask

    task automatic test_reset_midcount();
        do_reset();
        set_dly(1, 3);
        start[1] = 1'b1; tick(); start[1] = 1'b0;               // E0
        ticks(6);
        rst = 1'b1; tick(); rst = 1'b0;                         // +7
        chk_cnt++; if (active !== 4'b0000 || pending !== 4'b0000 || irq !== 1'b0) begin
            err_cnt++; $display("FAIL rst_mid got=%b/%b/%b exp=0000/0000/0", active, pending, irq);
        end
        ticks(20);
        chk_cnt++; if (pending !== 4'b0000) begin err_cnt++; $display("FAIL rst_no_expiry got=%b exp=0000", pending); end
        start[1] = 1'b1; tick(); start[1] = 1'b0;               // E1
        ticks(11);
        chk_cnt++; if (pending !== 4'b0000) begin err_cnt++; $display("FAIL rst_fresh_early got=%b exp=0000", pending); end
        tick();
        chk_cnt++; if (pending !== 4'b0010) begin err_cnt++; $display("FAIL rst_fresh got=%b exp=0010", pending); end
    endtask

    task automatic test_random();
        bit         e_irq;
        logic [1:0] e_id;
        bit [N-1:0] e_act;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 11) == 0) start[i] = ~start[i];
                stop[i] = ($urandom_range(0, 79) == 0);
                ack[i]  = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 7) == 0) set_dly(i, $urandom_range(0, 5));
            end
            if ($urandom_range(0, 15) == 0) periodic = 4'($urandom);
            if ($urandom_range(0, 15) == 0) irq_mask = 4'($urandom);
            tick();
            e_irq = 0; e_id = 2'd0;
            for (int i = N - 1; i >= 0; i--) begin
                if (m_pending[i] && irq_mask[i]) begin e_irq = 1; e_id = 2'(i); end
                e_act[i] = m_run[i];
            end
            chk_cnt++; if (active !== e_act) begin err_cnt++; $display("FAIL rnd_active c=%0d got=%b exp=%b", c, active, e_act); end
            chk_cnt++; if (pending !== m_pending) begin err_cnt++; $display("FAIL rnd_pending c=%0d got=%b exp=%b", c, pending, m_pending); end
            chk_cnt++; if (overrun !== m_overrun) begin err_cnt++; $display("FAIL rnd_overrun c=%0d got=%b exp=%b", c, overrun, m_overrun); end
            chk_cnt++; if (irq !== e_irq || irq_id !== e_id) begin err_cnt++; $display("FAIL rnd_irq c=%0d got=%b/%0d exp=%b/%0d", c, irq, irq_id, e_irq, e_id); end
        end
        rst = 1'b0; start = '0; stop = '0; ack = '0;
    endtask

    initial begin
        rst = 1'b1; start = '0; stop = '0; periodic = '0; irq_mask = '1; ack = '0; delay_ms = '0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_priority();
        test_retrigger();
        test_simultaneous();
        test_reset_midcount();
        test_random();
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/multi_timer_irq_controller.md
Name: multi_timer_irq_controller

Overview:
- Multi-channel millisecond delay/interrupt controller.
- Each of NCH channels is independently started, stopped, and configured as one-shot or periodic.
- Expiries latch into sticky pending bits. These are masked, priority-encoded, and presented to a consumer (LCD sequencer, clock tick logic) as a single irq with a channel id.
- Software/FSM clears pending bits with per-channel ack.

Parameters:
- MFREQ_KHZ, 20000, mclk cycles per millisecond (must be >= 1)
- NCH, 4, number of channels (1..16)
- DLY_W, 16, width of each channel's delay_ms field

Ports:
- mclk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  NCH  per-channel start request, rising-edge sensitive
- stop  in  NCH  per-channel stop, level, sampled each cycle
- periodic  in  NCH  mode per channel: 0 one-shot, 1 periodic; sampled on start
- delay_ms  in  NCH*DLY_W  channel i delay at bits [i*DLY_W +: DLY_W]; sampled on start
- irq_mask  in  NCH  1 = channel may raise irq
- ack  in  NCH  1-cycle pulse per bit, clears pending[i] and overrun[i]
- active  out  NCH  channel is in RUN
- pending  out  NCH  sticky expiry flags
- overrun  out  NCH  expiry occurred while pending already set
- irq  out  1  |(pending & irq_mask)
- irq_id  out  clog2(NCH) max 1  lowest index i with pending[i] & irq_mask[i]; 0 when irq=0

Behaviour:
- Reset: all outputs 0, all channels IDLE, all counters 0, start edge registers 0. Reset mid-operation aborts every channel with no expiry.
- Start edge detection:
  - start_q[i] registers start[i] each cycle.
  - The edge condition is start[i] & ~start_q[i], evaluated at clock edge E0.
- Per-channel FSM states: IDLE, RUN.
- On start edge (from IDLE or RUN, i.e. retrigger):
  - Enter RUN.
  - Latch dly[i] = max(delay_ms slice, 1) and mode[i] = periodic[i].
  - Clear cyc_cnt[i] (0..MFREQ_KHZ-1) and ms_cnt[i] (DLY_W bits).
- In RUN, every cycle cyc_cnt increments.
  - At cyc_cnt == MFREQ_KHZ-1: cyc_cnt wraps to 0 and ms_cnt increments.
  - Exactly MFREQ_KHZ cycles per ms, no +1 slip.
- Expiry: at the cycle where cyc_cnt == MFREQ_KHZ-1 and ms_cnt == dly-1.
  - pending[i] is set at edge E0 + dly*MFREQ_KHZ.
  - One-shot: go to IDLE.
  - Periodic: ms_cnt returns to 0 and RUN continues. Next expiry follows exactly dly*MFREQ_KHZ cycles later, using the latched dly.
- Expiry while pending[i] already 1: overrun[i] set, pending[i] remains 1.
- stop[i] high: channel goes to IDLE, counters cleared. pending and overrun are untouched.
- Simultaneous events:
  - stop and start edge in the same cycle: stop wins, channel ends IDLE.
  - stop and expiry in the same cycle: stop wins, no pending set.
  - ack and expiry in the same cycle: set wins, pending stays 1 and overrun is not set.
- ack of a bit that is not pending: no effect.
- active[i] = (state == RUN).
- Latency: irq and irq_id are combinational from the pending/irq_mask registers, so irq is visible in the same cycle pending rises. Masking never clears pending; unmasking a pending channel asserts irq immediately.
- Priority: lowest channel index wins; irq_id is stable while the winning bit stays pending.
- Width rules:
  - ms_cnt and dly are DLY_W bits.
  - delay_ms = 0 is treated as 1 ms.
  - Maximum delay is 2^DLY_W - 1 ms; no counter wraps inside a period.
  - cyc_cnt width is clog2(MFREQ_KHZ), min 1.

Test Plan (MFREQ_KHZ=4, NCH=4, DLY_W=16):
- Ch0 one-shot, delay 3, start edge at cycle 10 -> pending[0] and irq rise at cycle 22, irq_id=0, active[0] drops at 22; ack[0] at 25 -> pending[0]=0 and irq=0 at 26.
- Ch1 periodic, delay 2, start at 0, no acks -> pending[1] at 8; overrun[1] at 16; still RUN at 24. stop[1] at 30 -> active[1]=0, pending/overrun kept.
- Ch2 delay 0 -> expiry after 4 cycles. Ch3 start at 0 and ch2 start at 0 with equal delays -> both pending, irq_id=2; ack[2] -> irq_id=3.
- Retrigger: ch0 delay 5, start at 0, second start edge at 12 -> no expiry at 20, pending at 32.
- Simultaneous: ack[0] in the expiry cycle -> pending[0]=1, overrun[0]=0. stop in the expiry cycle -> pending stays 0. irq_mask[0]=0 with pending[0]=1 -> irq=0, then unmask -> irq=1 the same cycle.
- rst asserted mid-count at cycle 7 for ch1 delay 3 -> all outputs 0 next cycle, no expiry ever. A fresh start after reset expires exactly 12 cycles later.
